// File: rtl/perf_pkg.sv
// perf_pkg
// Shared types and helpers for the performance/trace observation block.
//   state_t       : run-state of the observer (IDLE, RUN)
//   trace_entry_t : one retirement trace entry {pc, rd, data}
//   TRACE_W       : packed width of trace_entry_t (69)
//   sat_inc       : saturating increment used by every counter
package perf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned TRACE_W = 69;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } trace_entry_t;

  // Increments val when en is set, unless val already sits at the all-ones
  // value for a counter of the given width. Callers widen to 64 bits and
  // truncate the result back to their own counter width.
  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input int unsigned width,
                                          input logic en);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    if (en && (val < max_val)) begin
      return val + 64'd1;
    end
    return val;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
// Synchronous FIFO with a valid/ready output side.
//   clk_i       : clock
//   rst_i       : asynchronous active-low reset
//   clr_i       : synchronous clear of both pointers (contents discarded)
//   push_i      : write request; ignored when full unless a pop happens too
//   push_data_i : data to write
//   valid_o     : head entry available
//   ready_i     : consumer takes the head entry when valid_o is high
//   data_o      : head entry, forced to zero while empty
//   full_o      : all DEPTH entries occupied
//   empty_o     : no entries
// DEPTH must be a power of two and at least 2.
module trace_fifo #(
  parameter int unsigned WIDTH = 69,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             pop;
  logic             write;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid_o = ~empty_o;
  assign pop     = valid_o & ready_i;
  // When full, a simultaneous pop frees the head slot, so the push is kept.
  assign write   = push_i & (~full_o | pop);
  assign data_o  = valid_o ? mem[rd_ptr_q[AW-1:0]] : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (write) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: data_o is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (write && !clr_i) begin
      mem[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/perf_trace_unit.sv
// perf_trace_unit
// Run statistics and retirement trace for the CPU. Counts cycles, stalls,
// flushes and retired write-backs while in RUN, and streams register-file
// write-backs (except to x0) through a trace FIFO.
//   clk_i, rst_i (async active-low), start_i (run enable), clr_i (sync clear)
//   stall_i, flush_i, wb_valid_i, wb_rd_i, wb_data_i, wb_pc_i : events
//   cycle/stall/flush/retire/drop_cnt_o : saturating counters
//   trace_valid_o / trace_ready_i / trace_data_o : {pc, rd, data} stream
// Build option: define PERF_TRACE_EN to build the trace FIFO and drop
// counter; without it the trace outputs and drop_cnt_o are tied to zero.
module perf_trace_unit
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clr_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               wb_valid_i,
  input  logic [4:0]         wb_rd_i,
  input  logic [31:0]        wb_data_i,
  input  logic [31:0]        wb_pc_i,
  output logic [CNT_W-1:0]   cycle_cnt_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o,
  output logic [CNT_W-1:0]   retire_cnt_o,
  output logic [CNT_W-1:0]   drop_cnt_o,
  output logic               trace_valid_o,
  input  logic               trace_ready_i,
  output logic [TRACE_W-1:0] trace_data_o
);

  state_t           state_q;
  state_t           state_d;
  logic             run;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] retire_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: follow start_i, with clr_i overriding everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)  state_d = RUN;
      RUN:     if (!start_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr_i) state_d = IDLE;
  end

  // State-derived outputs.
  always_comb begin
    run = 1'b0;
    if (state_q == RUN) run = 1'b1;
  end

  // Event counters; a flush takes precedence over a simultaneous stall.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_q  <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
      retire_q <= '0;
    end else if (clr_i) begin
      cycle_q  <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
      retire_q <= '0;
    end else if (run) begin
      cycle_q  <= CNT_W'(sat_inc(64'(cycle_q), CNT_W, 1'b1));
      stall_q  <= CNT_W'(sat_inc(64'(stall_q), CNT_W, stall_i & ~flush_i));
      flush_q  <= CNT_W'(sat_inc(64'(flush_q), CNT_W, flush_i));
      retire_q <= CNT_W'(sat_inc(64'(retire_q), CNT_W, wb_valid_i));
    end
  end

  assign cycle_cnt_o  = cycle_q;
  assign stall_cnt_o  = stall_q;
  assign flush_cnt_o  = flush_q;
  assign retire_cnt_o = retire_q;

`ifdef PERF_TRACE_EN
  trace_entry_t     push_entry;
  logic             push;
  logic             drop;
  logic             fifo_full;
  logic             unused_fifo_empty;
  logic [CNT_W-1:0] drop_q;

  // Writes to x0 retire but carry no architectural result worth tracing.
  assign push       = run & ~clr_i & wb_valid_i & (wb_rd_i != 5'd0);
  assign push_entry = '{pc: wb_pc_i, rd: wb_rd_i, data: wb_data_i};
  // A full FIFO only loses the entry if the head is not leaving this cycle.
  assign drop       = push & fifo_full & ~trace_ready_i;

  trace_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_trace_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (clr_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .valid_o     (trace_valid_o),
    .ready_i     (trace_ready_i),
    .data_o      (trace_data_o),
    .full_o      (fifo_full),
    .empty_o     (unused_fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      drop_q <= '0;
    else if (clr_i)  drop_q <= '0;
    else             drop_q <= CNT_W'(sat_inc(64'(drop_q), CNT_W, drop));
  end

  assign drop_cnt_o = drop_q;
`else
  logic unused_trace_inputs;

  assign unused_trace_inputs = ^{trace_ready_i, wb_rd_i, wb_data_i, wb_pc_i};
  assign trace_valid_o       = 1'b0;
  assign trace_data_o        = '0;
  assign drop_cnt_o          = '0;
`endif

endmodule

// File: tb/tb_perf_trace_unit.sv
// tb_perf_trace_unit
// Directed bench for perf_trace_unit. Expected trace entries go into a
// scoreboard queue as the write-backs are driven and are popped whenever the
// DUT hands an entry over. A second instance with 3-bit counters exercises
// counter saturation. Works with and without PERF_TRACE_EN.
module tb_perf_trace_unit;
  import perf_pkg::*;

`ifdef PERF_TRACE_EN
  localparam bit TRACE_ON = 1'b1;
`else
  localparam bit TRACE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sat_start;
  logic        clr;
  logic        stall;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        ready;

  logic [31:0]        cycle_cnt, stall_cnt, flush_cnt, retire_cnt, drop_cnt;
  logic               trace_valid;
  logic [TRACE_W-1:0] trace_data;

  logic [2:0]         sat_cycle, sat_stall, sat_flush, sat_retire, sat_drop;
  logic               sat_valid;
  logic [TRACE_W-1:0] sat_data;

  int vectors     = 0;
  int miscompares = 0;
  int emitted     = 0;

  logic [TRACE_W-1:0] sb [$];
  logic [TRACE_W-1:0] held_data;
  logic               held_valid = 1'b0;
  logic [TRACE_W-1:0] exp_entry;

  always #5 clk = ~clk;

  perf_trace_unit #(.CNT_W(32), .FIFO_DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .clr_i(clr),
    .stall_i(stall), .flush_i(flush), .wb_valid_i(wb_valid),
    .wb_rd_i(wb_rd), .wb_data_i(wb_data), .wb_pc_i(wb_pc),
    .cycle_cnt_o(cycle_cnt), .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt), .retire_cnt_o(retire_cnt),
    .drop_cnt_o(drop_cnt), .trace_valid_o(trace_valid),
    .trace_ready_i(ready), .trace_data_o(trace_data)
  );

  perf_trace_unit #(.CNT_W(3), .FIFO_DEPTH(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_n), .start_i(sat_start), .clr_i(clr),
    .stall_i(stall), .flush_i(flush), .wb_valid_i(wb_valid),
    .wb_rd_i(wb_rd), .wb_data_i(wb_data), .wb_pc_i(wb_pc),
    .cycle_cnt_o(sat_cycle), .stall_cnt_o(sat_stall),
    .flush_cnt_o(sat_flush), .retire_cnt_o(sat_retire),
    .drop_cnt_o(sat_drop), .trace_valid_o(sat_valid),
    .trace_ready_i(ready), .trace_data_o(sat_data)
  );

  function automatic logic [TRACE_W-1:0] mk(input logic [31:0] pc,
                                            input logic [4:0] rd,
                                            input logic [31:0] d);
    return {pc, rd, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic applyStimulus(input logic st, input logic sl, input logic fl,
                               input logic wv, input logic [4:0] rd,
                               input logic [31:0] pc, input logic [31:0] d);
    start    = st;
    stall    = sl;
    flush    = fl;
    wb_valid = wv;
    wb_rd    = rd;
    wb_pc    = pc;
    wb_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Consumer-side monitor: handshakes pop the scoreboard, and a held entry
  // must not change while the consumer is stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid && trace_valid)
        checkOutput("trace_stable", trace_data, held_data);
      if (trace_valid && !ready) begin
        held_valid = 1'b1;
        held_data  = trace_data;
      end else begin
        held_valid = 1'b0;
      end
      if (trace_valid && ready) begin
        emitted++;
        checkOutput("sb_has_entry", (sb.size() > 0), 1'b1);
        if (sb.size() > 0) checkOutput("trace_entry", trace_data, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 0; sat_start = 0; clr = 0; stall = 0; flush = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; wb_pc = 0; ready = 0;
    #12;
    checkOutput("rst_cycle", cycle_cnt, 0);
    checkOutput("rst_stall", stall_cnt, 0);
    checkOutput("rst_flush", flush_cnt, 0);
    checkOutput("rst_retire", retire_cnt, 0);
    checkOutput("rst_drop", drop_cnt, 0);
    checkOutput("rst_valid", trace_valid, 0);
    checkOutput("rst_data", trace_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 10 cycles of start with no events.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("idle_run_valid", trace_valid, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("run10_cycle", cycle_cnt, 10);
    checkOutput("run10_stall", stall_cnt, 0);
    checkOutput("run10_flush", flush_cnt, 0);
    checkOutput("run10_retire", retire_cnt, 0);
    checkOutput("run10_drop", drop_cnt, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_hold_cycle", cycle_cnt, 10);

    // Stalls and flushes, one flush overlapping a stall.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("sf_stall", stall_cnt, 2);
    checkOutput("sf_flush", flush_cnt, 2);
    checkOutput("sf_cycle", cycle_cnt, 15);

    // One traced write and one write to x0.
    ready = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    exp_entry = mk(32'h4, 5'd1, 32'h5);
    if (TRACE_ON) sb.push_back(exp_entry);
    applyStimulus(1, 0, 0, 1, 5'd1, 32'h4, 32'h5);
    checkOutput("wb_valid_next", trace_valid, TRACE_ON);
    checkOutput("wb_data_next", trace_data, TRACE_ON ? exp_entry : '0);
    applyStimulus(1, 0, 0, 1, 5'd0, 32'h8, 32'h7);
    checkOutput("x0_no_entry", trace_valid, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("wb_retire", retire_cnt, 2);
    checkOutput("wb_cycle", cycle_cnt, 18);
    checkOutput("wb_emitted", emitted, TRACE_ON ? 1 : 0);

    // Overfill with ready low: rd=9 and rd=10 are dropped.
    ready = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      if (TRACE_ON && i <= 8) sb.push_back(mk(32'h100 + 32'(4*i), 5'(i), 32'(32'h11*i)));
      applyStimulus(1, 0, 0, 1, 5'(i), 32'h100 + 32'(4*i), 32'(32'h11*i));
    end
    checkOutput("full_drop", drop_cnt, TRACE_ON ? 2 : 0);
    checkOutput("full_head", trace_data, TRACE_ON ? mk(32'h104, 5'd1, 32'h11) : '0);

    // Full FIFO, push and pop together: accepted, no drop.
    ready = 1'b1;
    if (TRACE_ON) sb.push_back(mk(32'h200, 5'd11, 32'hBB));
    applyStimulus(1, 0, 0, 1, 5'd11, 32'h200, 32'hBB);
    checkOutput("pushpop_drop", drop_cnt, TRACE_ON ? 2 : 0);
    // Still full: a push without a pop is dropped.
    ready = 1'b0;
    applyStimulus(1, 0, 0, 1, 5'd12, 32'h204, 32'hCC);
    checkOutput("still_full_drop", drop_cnt, TRACE_ON ? 3 : 0);
    checkOutput("pushpop_head", trace_data, TRACE_ON ? mk(32'h108, 5'd2, 32'h22) : '0);

    // Leave RUN and drain in IDLE.
    ready = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("ovf_retire", retire_cnt, 14);
    for (int i = 0; i < 20 && trace_valid; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("drain_valid", trace_valid, 0);
    checkOutput("drain_sb_empty", sb.size(), 0);
    checkOutput("drain_emitted", emitted, TRACE_ON ? 10 : 0);

    // Mid-run clear with an entry pending.
    ready = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    if (TRACE_ON) sb.push_back(mk(32'h300, 5'd3, 32'h33));
    applyStimulus(1, 1, 0, 1, 5'd3, 32'h300, 32'h33);
    checkOutput("pre_clr_valid", trace_valid, TRACE_ON);
    clr = 1'b1;
    sb.delete();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    clr = 1'b0;
    checkOutput("clr_cycle", cycle_cnt, 0);
    checkOutput("clr_stall", stall_cnt, 0);
    checkOutput("clr_retire", retire_cnt, 0);
    checkOutput("clr_drop", drop_cnt, 0);
    checkOutput("clr_valid", trace_valid, 0);
    checkOutput("clr_data", trace_data, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("clr_idle_cycle", cycle_cnt, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("clr_rerun_cycle", cycle_cnt, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Saturation on the 3-bit instance.
    sat_start = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 1, 5'd0, 0, 0);
    checkOutput("sat_cycle_max_m1", sat_cycle, 6);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 5'd0, 0, 0);
    checkOutput("sat_cycle", sat_cycle, 7);
    checkOutput("sat_stall", sat_stall, 7);
    checkOutput("sat_retire", sat_retire, 7);
    checkOutput("sat_flush", sat_flush, 0);
    checkOutput("sat_drop", sat_drop, 0);
    checkOutput("sat_valid", sat_valid, 0);
    checkOutput("sat_data", sat_data, 0);
    sat_start = 1'b0;
    checkOutput("main_idle_during_sat", cycle_cnt, 2);

    // Asynchronous reset in the middle of a run with an entry pending.
    ready = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 5'd5, 32'h400, 32'h55);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("arst_cycle", cycle_cnt, 0);
    checkOutput("arst_retire", retire_cnt, 0);
    checkOutput("arst_drop", drop_cnt, 0);
    checkOutput("arst_valid", trace_valid, 0);
    checkOutput("arst_data", trace_data, 0);
    #3;
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("post_rst_no_entry", trace_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/perf_trace_unit.md
# perf_trace_unit

Hardware observation block inside `CPU` that produces the run statistics and retirement trace a bench or host reads out. It counts cycles, pipeline stalls, flushes and retired instructions, and streams each register-file write-back as a trace entry over a valid/ready interface backed by a small FIFO. It sits beside the hazard-detection unit and the WB stage and has no effect on pipeline behaviour.

## Interface
Parameters:
- `CNT_W`, 32: width of every counter.
- `FIFO_DEPTH`, 8: trace FIFO entries; must be a power of two, at least 2.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: CPU run enable; the same signal the CPU core receives.
- `clr_i` in 1: synchronous clear of all counters and the FIFO.
- `stall_i` in 1: hazard-detection stall.
- `flush_i` in 1: IF flush (taken branch).
- `wb_valid_i` in 1: WB stage writes the register file this cycle.
- `wb_rd_i` in 5: WB destination register.
- `wb_data_i` in 32: WB write data.
- `wb_pc_i` in 32: PC of the instruction in WB.
- `cycle_cnt_o` out CNT_W: cycles spent in RUN.
- `stall_cnt_o` out CNT_W: stall cycles.
- `flush_cnt_o` out CNT_W: flush cycles.
- `retire_cnt_o` out CNT_W: retired write-backs.
- `drop_cnt_o` out CNT_W: trace entries lost because the FIFO was full.
- `trace_valid_o` out 1: a trace entry is available.
- `trace_ready_i` in 1: the consumer accepts the entry.
- `trace_data_o` out 69: entry packed as {pc[31:0], rd[4:0], data[31:0]}.

## Operation
- State machine:
  - IDLE to RUN when `start_i`=1.
  - RUN to IDLE when `start_i`=0.
  - `clr_i` forces IDLE and zeroes all counters and FIFO pointers. `clr_i` has priority over every other input.
- Counting happens only in RUN:
  - `cycle_cnt_o` increments every cycle.
  - `stall_cnt_o` increments when `stall_i` & ~`flush_i`.
  - `flush_cnt_o` increments when `flush_i`.
  - `retire_cnt_o` increments when `wb_valid_i`.
- All counters saturate at 2^CNT_W−1. They never wrap.
- Trace push happens in RUN when `wb_valid_i` & (`wb_rd_i`≠0). A write to x0 is counted as retired but is not traced.
- When the FIFO is full and a push occurs without a pop, the entry is dropped and `drop_cnt_o` increments.
- When the FIFO is full and a push and a pop occur in the same cycle, the push is accepted.
- The FIFO drains in every state, including IDLE. Only `clr_i` discards its contents.
- Handshake: an entry transfers on a cycle with `trace_valid_o` & `trace_ready_i`.
  - Once `trace_valid_o` is high, it stays high and `trace_data_o` stays stable until the transfer.
- Entries come out in push order.

## Timing
- Reset values:
  - All counters are 0.
  - `trace_valid_o` is 0.
  - `trace_data_o` is 0.
  - State is IDLE.
- Counters are registered. An event in cycle N is visible on the output in cycle N+1.
- The `start_i` rising edge in cycle N is sampled at that edge, so cycle N+1 is the first counted cycle.
- Trace latency: a push in cycle N can raise `trace_valid_o` in cycle N+1 at the earliest.
- Throughput: one entry per cycle when `trace_ready_i` is held high.
- When `rst_i` is asserted mid-run, everything returns to reset values immediately. No partial entry is emitted afterward.

## Configuration
- `PERF_TRACE_EN` defined: the trace FIFO, trace ports and `drop_cnt_o` logic are built as described.
- `PERF_TRACE_EN` undefined:
  - The FIFO is not instantiated.
  - `trace_valid_o` is 0, `trace_data_o` is 0 and `drop_cnt_o` is 0.
  - `trace_ready_i` is ignored.
  - All four performance counters behave identically to the defined case.

## Structure
- Package `perf_pkg` holds:
  - the state enum (IDLE, RUN);
  - the `trace_entry_t` packed struct {pc, rd, data};
  - the constant `TRACE_W`=69.
- Sub-module `trace_fifo`: synchronous FIFO parameterised on width and depth, with a valid/ready output and full/empty flags. It is instantiated only under `PERF_TRACE_EN`.
- Counter saturation is a shared function in `perf_pkg`.

## Test plan
- Reset, then hold `start_i`=1 for 10 cycles with no events: `cycle_cnt_o`=10, all other counters 0, `trace_valid_o`=0 throughout.
- In RUN:
  - pulse `stall_i` for 3 cycles;
  - pulse `flush_i` for 2 cycles, one of them overlapping a stall;
  - result: `stall_cnt_o`=2, `flush_cnt_o`=2.
- With `trace_ready_i`=1, issue WB writes {pc=0x04, rd=1, data=5} and {pc=0x08, rd=0, data=7}:
  - exactly one entry is emitted, 0x00000004_01_00000005, one cycle after the push;
  - `retire_cnt_o`=2.
- With `trace_ready_i`=0, issue 10 valid WB writes (FIFO_DEPTH=8) to rd=1..10:
  - `drop_cnt_o`=2;
  - after raising ready, entries rd=1..8 arrive in order;
  - `trace_data_o` stays stable while ready is low.
- With the FIFO full, push and pop in the same cycle: no drop, occupancy stays 8.
- Preset `cycle_cnt_o` to 2^CNT_W−2 by force, then run 3 cycles: it holds at all-ones.
- Mid-run `clr_i`: counters read 0 and `trace_valid_o`=0 on the next cycle.
- Mid-run `rst_i`=0: outputs reach reset values without waiting for a clock edge.
